// File: rtl/my_xor_pkg.sv
// my_xor shared definitions: default widths and saturating increment.
// Imported by my_xor and my_xor_sat_cnt.
package my_xor_pkg;

  localparam int unsigned DEF_WIDTH = 1;
  localparam int unsigned DEF_CNT_W = 16;

  // Widest counter the helper supports.
  localparam int unsigned SAT_MAX_W = 32;

  // Returns v+1 unless v already equals max, in which case v is held.
  function automatic logic [SAT_MAX_W-1:0] sat_inc(
    input logic [SAT_MAX_W-1:0] v,
    input logic [SAT_MAX_W-1:0] max
  );
    logic [SAT_MAX_W-1:0] r;
    r = v;
    if (v < max) begin
      r = v + 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/my_xor_sat_cnt.sv
// my_xor_sat_cnt: saturating up-counter, sync active-high rst and clr.
// Ports: clk, rst, clr_i, inc_i, cnt_o[W-1:0]. rst beats clr beats inc.
module my_xor_sat_cnt
  import my_xor_pkg::*;
#(
  parameter int unsigned W = DEF_CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  localparam logic [W-1:0] MAX = {W{1'b1}};

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = W'(sat_inc(SAT_MAX_W'(cnt_q), SAT_MAX_W'(MAX)));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/my_xor.sv
// my_xor: bitwise XOR with registered copy, parity and sticky diff flag.
// Ports: a,b -> out (comb), clk, rst (sync, high), clr, out_q, parity,
// diff_seen; diff_cnt only when MY_XOR_STATS_EN is defined.
module my_xor
  import my_xor_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] out,
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  output logic [WIDTH-1:0] out_q,
  output logic             parity,
  output logic             diff_seen
`ifdef MY_XOR_STATS_EN
  ,
  output logic [CNT_W-1:0] diff_cnt
`endif
);

  logic [WIDTH-1:0] out_reg_q;
  logic             seen_q;
  logic             seen_d;
  logic             diff;

  // Pure combinational path; no clock or reset involvement.
  assign out    = a ^ b;
  assign parity = ^out;
  assign diff   = |out;

  // clr wins over a fresh difference on the same edge.
  always_comb begin
    seen_d = seen_q;
    if (clr) begin
      seen_d = 1'b0;
    end else if (diff) begin
      seen_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_reg_q <= '0;
      seen_q    <= 1'b0;
    end else begin
      out_reg_q <= out;
      seen_q    <= seen_d;
    end
  end

  assign out_q     = out_reg_q;
  assign diff_seen = seen_q;

`ifdef MY_XOR_STATS_EN
  my_xor_sat_cnt #(
    .W(CNT_W)
  ) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr_i(clr),
    .inc_i(diff),
    .cnt_o(diff_cnt)
  );
`else
  // Counter absent; CNT_W kept only for a uniform parameter list.
  localparam int unsigned CntWUnused = CNT_W;
`endif

endmodule

// File: tb/tb_my_xor.sv
// tb_my_xor: directed checks of my_xor at WIDTH=1 and WIDTH=8.
// Counter checks run when MY_XOR_STATS_EN is defined.
module tb_my_xor;

  logic       clk;
  logic       rst;
  logic       clr;
  logic [2:0] a_w;
  logic [2:0] b_w;
  logic       out1;
  logic       outq1;
  logic       par1;
  logic       seen1;
  logic [7:0] a8;
  logic [7:0] b8;
  logic [7:0] out8;
  logic [7:0] outq8;
  logic       par8;
  logic       seen8;
`ifdef MY_XOR_STATS_EN
  logic [1:0]  cnt1;
  logic [15:0] cnt8;
`endif

  int n_chk;
  int n_pass;

  // Wide stimulus lands on 1-bit ports through their LSB only.
  my_xor #(
    .WIDTH(1),
    .CNT_W(2)
  ) dut (
    .a        (a_w[0:0]),
    .b        (b_w[0:0]),
    .out      (out1),
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .out_q    (outq1),
    .parity   (par1),
    .diff_seen(seen1)
`ifdef MY_XOR_STATS_EN
    ,
    .diff_cnt (cnt1)
`endif
  );

  my_xor #(
    .WIDTH(8)
  ) dut8 (
    .a        (a8),
    .b        (b8),
    .out      (out8),
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .out_q    (outq8),
    .parity   (par8),
    .diff_seen(seen8)
`ifdef MY_XOR_STATS_EN
    ,
    .diff_cnt (cnt8)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic edge_chk();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    rst    = 1'b1;
    clr    = 1'b0;
    a_w    = 3'd0;
    b_w    = 3'd0;
    a8     = 8'h00;
    b8     = 8'h00;

    // Reset state
    edge_chk();
    chk("rst_outq", 32'(outq1), 32'd0);
    chk("rst_seen", 32'(seen1), 32'd0);
    chk("rst_outq8", 32'(outq8), 32'd0);
`ifdef MY_XOR_STATS_EN
    chk("rst_cnt", 32'(cnt1), 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;

    // Combinational truth table with truncation
    a_w = 3'd0; b_w = 3'd0; #100;
    chk("tt_00", 32'(out1), 32'd0);
    chk("tt_00_par", 32'(par1), 32'd0);
    a_w = 3'd3; #100;
    chk("tt_a3", 32'(out1), 32'd1);
    chk("tt_a3_par", 32'(par1), 32'd1);
    b_w = 3'd5; #100;
    chk("tt_b5", 32'(out1), 32'd0);
    a_w = 3'd4; #100;
    chk("tt_a4", 32'(out1), 32'd1);

    // Bitwise WIDTH=8
    a8 = 8'hF0; b8 = 8'h3C; #1;
    chk("w8_out", 32'(out8), 32'hCC);
    chk("w8_par", 32'(par8), 32'd0);
    b8 = 8'h3D; #1;
    chk("w8_out2", 32'(out8), 32'hCD);
    chk("w8_par2", 32'(par8), 32'd1);
    edge_chk();
    chk("w8_outq", 32'(outq8), 32'hCD);
    chk("w8_seen", 32'(seen8), 32'd1);

    // Fresh reset, then latency with clr on the same edge
    @(negedge clk);
    rst = 1'b1; a_w = 3'd0; b_w = 3'd0;
    @(negedge clk);
    rst = 1'b0;
    chk("rst2_seen", 32'(seen1), 32'd0);
    a_w = 3'd1; b_w = 3'd0; clr = 1'b1; #1;
    chk("lat_out_now", 32'(out1), 32'd1);
    chk("lat_outq_pre", 32'(outq1), 32'd0);
    edge_chk();
    chk("lat_outq_post", 32'(outq1), 32'd1);
    chk("clr_prio_seen", 32'(seen1), 32'd0);
    @(negedge clk);
    clr = 1'b0;
    edge_chk();
    chk("seen_set", 32'(seen1), 32'd1);
    @(negedge clk);
    a_w = 3'd0; b_w = 3'd0;
    edge_chk();
    chk("seen_hold", 32'(seen1), 32'd1);
    chk("outq_zero", 32'(outq1), 32'd0);
    edge_chk();
    chk("seen_hold2", 32'(seen1), 32'd1);

    // Reset mid-operation
    @(negedge clk);
    a_w = 3'd1;
    edge_chk();
    chk("mid_outq1", 32'(outq1), 32'd1);
    @(negedge clk);
    rst = 1'b1; #1;
    chk("mid_out_rst", 32'(out1), 32'd1);
    chk("mid_par_rst", 32'(par1), 32'd1);
    edge_chk();
    chk("mid_outq0", 32'(outq1), 32'd0);
    chk("mid_seen0", 32'(seen1), 32'd0);
    chk("mid_out", 32'(out1), 32'd1);
    @(negedge clk);
    rst = 1'b0;

    // clr alone drops the flag
    edge_chk();
    chk("seen_reset", 32'(seen1), 32'd1);
    @(negedge clk);
    clr = 1'b1; a_w = 3'd0;
    edge_chk();
    chk("clr_seen", 32'(seen1), 32'd0);

`ifdef MY_XOR_STATS_EN
    // Saturation at CNT_W=2
    @(negedge clk);
    clr = 1'b0; a_w = 3'd1; b_w = 3'd0;
    edge_chk(); chk("cnt_1", 32'(cnt1), 32'd1);
    edge_chk(); chk("cnt_2", 32'(cnt1), 32'd2);
    edge_chk(); chk("cnt_3", 32'(cnt1), 32'd3);
    edge_chk(); chk("cnt_sat4", 32'(cnt1), 32'd3);
    edge_chk(); chk("cnt_sat5", 32'(cnt1), 32'd3);
    @(negedge clk);
    clr = 1'b1;
    edge_chk(); chk("cnt_clr", 32'(cnt1), 32'd0);
`endif

    @(negedge clk);
    clr = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected done");
    $fatal(1);
  end

endmodule
